// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: shared state encoding, command bundle and default timing
// constants for the stopwatch button front-end.
package stopwatch_ctrl_pkg;

   // Mode FSM encoding; state_o exposes these values directly.
   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_RUNNING = 3'd2,
      ST_LAP     = 3'd3,
      ST_STOPPED = 3'd4
   } sw_state_e;

   // One-cycle command pulses toward the stopwatch core.
   typedef struct packed {
      logic start;
      logic stop;
      logic split;
      logic zero;
   } cmd_t;

   // 10 ms debounce and 2 s long-press at 50 MHz.
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_LONG_CYCLES     = 100000000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and press-edge detect for
// one raw push-button. A level change is accepted only after the synchronised
// sample has differed from the accepted level, without changing, for
// DEBOUNCE_CYCLES counter steps; press is the one-cycle rising edge of that
// accepted level.
module btn_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic          sync_q;
   logic          level_q;
   logic [CW-1:0] cnt;

   // synchroniser, previous-sample copy and edge-detect history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta    <= 1'b0;
         sync    <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
      end else begin
         meta    <= raw;
         sync    <= meta;
         sync_q  <= sync;
         level_q <= level;
      end
   end

   // stability counter: restart on agreement or on any bounce, accept on expiry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if ((sync == level) || (sync != sync_q)) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt   <= '0;
         level <= sync;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // release is deliberately silent; only the rising edge is an event
   assign press = level & ~level_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-button front-end for the BCD stopwatch core.
// Button A = start/stop, button B = lap/zero. Each button is debounced, and
// a mode FSM turns press events into registered one-cycle command pulses.
// Optional feature macro: LONG_PRESS_EN (holding B for LONG_CYCLES forces a
// return to IDLE with a zero pulse, the "hard reset" gesture).
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_a,
   input  logic       btn_b,
   output logic       start,
   output logic       stop,
   output logic       split,
   output logic       zero,
   output logic       lap_active,
   output logic [2:0] state_o
);

   sw_state_e state;
   sw_state_e state_nx;
   cmd_t      cmd;
   cmd_t      cmd_nx;
   logic      level_a;
   logic      level_b;
   logic      press_a;
   logic      press_b;
   logic      long_evt;
   logic      unused_level;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_a),
      .level (level_a),
      .press (press_a)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_b),
      .level (level_b),
      .press (press_b)
   );

`ifdef LONG_PRESS_EN
   localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

   logic [HOLD_W-1:0] hold_cnt;

   // hold counter: runs while debounced B is high, saturates so a hold fires once
   always_ff @(posedge clk) begin
      if (!rst_n || !level_b) begin
         hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
         hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end

   // fires in the cycle the counter steps onto LONG_CYCLES
   assign long_evt     = level_b && (hold_cnt == HOLD_FIRE);
   assign unused_level = level_a;
`else
   // the hold length has no consumer without the long-press gesture
   localparam int UNUSED_LONG_CYCLES = LONG_CYCLES;
   assign long_evt     = 1'b0;
   assign unused_level = level_a ^ level_b;
`endif

   // next-state and command decode; A has priority, a coincident B is dropped
   always_comb begin
      state_nx = state;
      cmd_nx   = '0;
      case (state)
         ST_INIT: begin
            state_nx    = ST_IDLE;
            cmd_nx.zero = 1'b1;
         end
         ST_IDLE: begin
            if (press_a) begin
               state_nx     = ST_RUNNING;
               cmd_nx.start = 1'b1;
            end else if (press_b) begin
               cmd_nx.zero = 1'b1;
            end
         end
         ST_RUNNING: begin
            if (press_a) begin
               state_nx    = ST_STOPPED;
               cmd_nx.stop = 1'b1;
            end else if (press_b) begin
               state_nx     = ST_LAP;
               cmd_nx.split = 1'b1;
            end
         end
         ST_LAP: begin
            if (press_a) begin
               // halt and unfreeze the display in one step
               state_nx     = ST_STOPPED;
               cmd_nx.stop  = 1'b1;
               cmd_nx.split = 1'b1;
            end else if (press_b) begin
               state_nx     = ST_RUNNING;
               cmd_nx.split = 1'b1;
            end
         end
         ST_STOPPED: begin
            if (press_a) begin
               state_nx     = ST_RUNNING;
               cmd_nx.start = 1'b1;
            end else if (press_b) begin
               state_nx    = ST_IDLE;
               cmd_nx.zero = 1'b1;
            end
         end
         default: state_nx = ST_INIT;
      endcase
      // long hold overrides everything once past INIT
      if (long_evt && (state != ST_INIT)) begin
         state_nx     = ST_IDLE;
         cmd_nx       = '0;
         cmd_nx.zero  = 1'b1;
         cmd_nx.stop  = (state == ST_RUNNING) || (state == ST_LAP);
         cmd_nx.split = (state == ST_LAP);
      end
   end

   // state, command pulses and lap flag all register on the same edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         cmd        <= '0;
         lap_active <= 1'b0;
      end else begin
         state      <= state_nx;
         cmd        <= cmd_nx;
         lap_active <= (state_nx == ST_LAP);
      end
   end

   assign start   = cmd.start;
   assign stop    = cmd.stop;
   assign split   = cmd.split;
   assign zero    = cmd.zero;
   assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed steps from the test plan followed by random
// button traffic, every cycle compared against a behavioural model that
// debounces by run-length of the synchronised samples and applies the mode
// table directly.
module tb_stopwatch_ctrl;

   localparam int D = 4;
   localparam int L = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_a;
   logic       btn_b;
   logic       start;
   logic       stop;
   logic       split;
   logic       zero;
   logic       lap_active;
   logic [2:0] state_o;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_a      (btn_a),
      .btn_b      (btn_b),
      .start      (start),
      .stop       (stop),
      .split      (split),
      .zero       (zero),
      .lap_active (lap_active),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int edge_n = 0;

   // reference model state
   int m_state;
   bit m_start, m_stop, m_split, m_zero, m_lap;
   bit d1 [2];
   bit d2 [2];
   bit lastx [2];
   int run [2];
   bit lvl [2];
   bit pend [2];
   int rise_b;

   // observed pulse tallies
   int n_start, n_stop, n_split, n_zero, n_ss;
   int t_start, t_split_first, t_zero;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic model_edge(input bit a, input bit b, input bit rs);
      bit raw [2];
      bit x;
      bit lng;
      int nxt;
      raw[0] = a;
      raw[1] = b;
      if (!rs) begin
         m_state = 0;
         {m_start, m_stop, m_split, m_zero, m_lap} = '0;
         for (int i = 0; i < 2; i++) begin
            d1[i] = 0; d2[i] = 0; lastx[i] = 0; run[i] = 0; lvl[i] = 0; pend[i] = 0;
         end
         rise_b = -1;
         return;
      end
      lng = 0;
`ifdef LONG_PRESS_EN
      // long event lands L cycles after B's debounced level rose, if still held
      if (rise_b >= 0 && lvl[1] && (edge_n - rise_b) == L) lng = 1;
`endif
      nxt = m_state;
      {m_start, m_stop, m_split, m_zero} = '0;
      if (m_state == 0) begin
         nxt = 1; m_zero = 1;
      end else if (lng) begin
         nxt = 1; m_zero = 1;
         m_stop  = (m_state == 2 || m_state == 3);
         m_split = (m_state == 3);
      end else if (pend[0]) begin
         case (m_state)
            1: begin nxt = 2; m_start = 1; end
            2: begin nxt = 4; m_stop = 1; end
            3: begin nxt = 4; m_stop = 1; m_split = 1; end
            4: begin nxt = 2; m_start = 1; end
            default: ;
         endcase
      end else if (pend[1]) begin
         case (m_state)
            1: begin nxt = 1; m_zero = 1; end
            2: begin nxt = 3; m_split = 1; end
            3: begin nxt = 2; m_split = 1; end
            4: begin nxt = 1; m_zero = 1; end
            default: ;
         endcase
      end
      m_state = nxt;
      m_lap   = (nxt == 3);
      // debounce: accept a new level once D+1 consecutive synchronised samples agree
      for (int i = 0; i < 2; i++) begin
         x = d2[i]; d2[i] = d1[i]; d1[i] = raw[i];
         if (x == lastx[i]) run[i]++; else run[i] = 1;
         lastx[i] = x;
         pend[i] = 0;
         if (x != lvl[i] && run[i] >= D + 1) begin
            lvl[i]  = x;
            pend[i] = x;
            if (i == 1) rise_b = x ? edge_n : -1;
         end
      end
   endtask

   task automatic clr_tally();
      n_start = 0; n_stop = 0; n_split = 0; n_zero = 0; n_ss = 0;
      t_start = -1; t_split_first = -1; t_zero = -1;
   endtask

   task automatic step(input bit a, input bit b);
      btn_a = a;
      btn_b = b;
      @(posedge clk);
      edge_n++;
      model_edge(a, b, rst_n);
      #1;
      check("cycle", 32'({start, stop, split, zero, lap_active, state_o}),
            32'({m_start, m_stop, m_split, m_zero, m_lap, m_state[2:0]}));
      if (start) begin n_start++; t_start = edge_n; end
      if (stop) n_stop++;
      if (split) begin
         if (n_split == 0) t_split_first = edge_n;
         n_split++;
      end
      if (zero) begin n_zero++; t_zero = edge_n; end
      if (stop && split) n_ss++;
   endtask

   task automatic press(input bit a, input bit b);
      repeat (8) step(a, b);
      repeat (10) step(0, 0);
   endtask

   initial begin
      int a_edge;
      int len;
      bit ra, rb;
      rst_n = 1'b0; btn_a = 1'b0; btn_b = 1'b0;
      clr_tally();
      repeat (3) step(0, 0);
      check("reset_outputs", 32'({start, stop, split, zero, lap_active, state_o}), 32'd0);

      // 1: first cycle after release emits zero and enters IDLE
      rst_n = 1'b1;
      step(0, 0);
      check("init_zero", 32'(zero), 32'd1);
      check("init_state", 32'(state_o), 32'd1);
      check("init_others", 32'({start, stop, split, lap_active}), 32'd0);
      repeat (4) step(0, 0);

      // 2: A held 10 cycles -> one start, fixed latency, release silent
      clr_tally();
      a_edge = edge_n + 1;
      repeat (10) step(1, 0);
      repeat (12) step(0, 0);
      check("a_start_count", 32'(n_start), 32'd1);
      check("a_latency", 32'(t_start - a_edge), 32'(D + 3));
      check("a_state_running", 32'(state_o), 32'd2);
      check("a_release_silent", 32'(n_stop + n_zero + n_split), 32'd0);

      // 3: glitch ignored, then lap toggles
      clr_tally();
      repeat (3) step(0, 1);
      repeat (12) step(0, 0);
      check("glitch_no_pulse", 32'(n_split + n_zero + n_start + n_stop), 32'd0);
      clr_tally();
      press(0, 1);
      check("lap_split", 32'(n_split), 32'd1);
      check("lap_active_on", 32'(lap_active), 32'd1);
      clr_tally();
      press(0, 1);
      check("unlap_split", 32'(n_split), 32'd1);
      check("lap_active_off", 32'(lap_active), 32'd0);

      // 4: A in LAP -> stop+split together; B from STOPPED -> zero
      press(0, 1);
      clr_tally();
      press(1, 0);
      check("lap_a_stop_split", 32'(n_ss), 32'd1);
      check("lap_a_state", 32'(state_o), 32'd4);
      clr_tally();
      press(0, 1);
      check("stopped_b_zero", 32'(n_zero), 32'd1);
      check("stopped_b_state", 32'(state_o), 32'd1);

      // 5: simultaneous A and B while RUNNING -> A wins
      press(1, 0);
      check("run_again", 32'(state_o), 32'd2);
      clr_tally();
      press(1, 1);
      check("both_stop", 32'(n_stop), 32'd1);
      check("both_no_split", 32'(n_split + n_zero), 32'd0);
      check("both_state", 32'(state_o), 32'd4);

      // reset mid-press: the held A re-qualifies and starts once
      repeat (3) step(1, 0);
      rst_n = 1'b0;
      repeat (2) step(1, 0);
      rst_n = 1'b1;
      clr_tally();
      repeat (12) step(1, 0);
      repeat (10) step(0, 0);
      check("rst_hold_zero", 32'(n_zero), 32'd1);
      check("rst_hold_start", 32'(n_start), 32'd1);
      check("rst_hold_state", 32'(state_o), 32'd2);

`ifdef LONG_PRESS_EN
      // 6: long B hold while RUNNING -> split, then stop+split+zero
      clr_tally();
      repeat (30) step(0, 1);
      check("long_zero", 32'(n_zero), 32'd1);
      check("long_stop", 32'(n_stop), 32'd1);
      check("long_split", 32'(n_split), 32'd2);
      // counted from the debounced press, which the first split follows by one cycle
      check("long_delay", 32'(t_zero - t_split_first), 32'(L - 1));
      check("long_state", 32'(state_o), 32'd1);
      repeat (12) step(0, 0);
      check("long_once", 32'(n_zero + n_start), 32'd1);
`endif

      // random traffic, including glitches, overlaps and occasional resets
      for (int s = 0; s < 60; s++) begin
         ra  = 1'($urandom_range(0, 1));
         rb  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            repeat (2) step(ra, rb);
            rst_n = 1'b1;
         end
         repeat (len) step(ra, rb);
      end
      repeat (12) step(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
